im_frame_receiver_p: RTL and testbench



---
 rtl/im_frame_receiver_p_if.sv | 34 +++
 rtl/im_frame_receiver_p.sv | 255 +++++++++++++++++++++++++
 tb/tb_im_frame_receiver_p.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/im_frame_receiver_p_if.sv
// Signal bundle between the IM1/IM0 line, the frame receiver and the
// frame buffer/writer: line inputs plus the assembled word stream.
interface im_frame_receiver_p_if #(
    parameter int WORD_W      = 16,
    parameter int FRAME_WORDS = 95
);
    localparam int IDX_W = $clog2(FRAME_WORDS);

    // Line side (asynchronous to clk13MHz)
    logic              HO;
    logic              IM1;
    logic              IM0;

    // Word stream towards the frame buffer
    logic [WORD_W-1:0] dout;
    logic              iVal;
    logic [IDX_W-1:0]  cntWord;
    logic              frmDone;
    logic              frmErr;
    logic [1:0]        errCode;
    logic              busy;

    // Receiver: samples the line, drives the word stream.
    modport master (
        input  HO, IM1, IM0,
        output dout, iVal, cntWord, frmDone, frmErr, errCode, busy
    );

    // Environment: drives the line, consumes the word stream.
    modport slave (
        output HO, IM1, IM0,
        input  dout, iVal, cntWord, frmDone, frmErr, errCode, busy
    );
endinterface

// File: rtl/im_frame_receiver_p.sv
// Parametrised IM1/IM0 frame receiver.
// Qualifies the HO frame marker and the IM1/IM0 pulse lines with a run-length
// filter, assembles WORD_W-bit words MSB-first and streams FRAME_WORDS words
// per frame. Aborts the frame on a bit-gap timeout or on both lines high.
module im_frame_receiver_p #(
    parameter int WORD_W      = 16,
    parameter int FRAME_WORDS = 95,
    parameter int FILT_LEN    = 21,
    parameter int GAP_MAX     = 1023
) (
    input logic                   clk13MHz,
    input logic                   nRST,
    im_frame_receiver_p_if.master bus
);
    localparam int IDX_W = $clog2(FRAME_WORDS);
    localparam int FCW   = $clog2(FILT_LEN + 1);
    localparam int GCW   = $clog2(GAP_MAX + 1);
    localparam int BCW   = $clog2(WORD_W);

    localparam logic [FCW-1:0]   FILT_TOP  = FCW'(FILT_LEN);
    localparam logic [FCW-1:0]   FILT_LAST = FCW'(FILT_LEN - 1);
    localparam logic [GCW-1:0]   GAP_LAST  = GCW'(GAP_MAX - 1);
    localparam logic [BCW-1:0]   BIT_LAST  = BCW'(WORD_W - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FRAME_WORDS - 1);

    localparam logic [1:0] ERR_GAP  = 2'b01;
    localparam logic [1:0] ERR_BOTH = 2'b10;

    typedef enum logic [1:0] {
        ARM  = 2'd0,   // waiting for HO low
        SYNC = 2'd1,   // counting the HO-high marker
        RECV = 2'd2    // assembling words
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [1:0] ho_sync;
    logic [1:0] im1_sync;
    logic [1:0] im0_sync;
    logic       ho_s;
    logic       im1_s;
    logic       im0_s;

    // Two-flop synchronisers for the three asynchronous line inputs.
    always_ff @(posedge clk13MHz) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (nRST) begin
            ho_sync  <= '0;
            im1_sync <= '0;
            im0_sync <= '0;
        end else begin
            ho_sync  <= {ho_sync[0],  bus.HO};
            im1_sync <= {im1_sync[0], bus.IM1};
            im0_sync <= {im0_sync[0], bus.IM0};
        end
    end

    assign ho_s  = ho_sync[1];
    assign im1_s = im1_sync[1];
    assign im0_s = im0_sync[1];

    // ------------------------------------------------------------------
    // Pulse qualifier
    // ------------------------------------------------------------------
    logic [FCW-1:0] hi1_cnt;    // consecutive IM1-high cycles, saturating
    logic [FCW-1:0] hi0_cnt;    // consecutive IM0-high cycles, saturating
    logic [FCW-1:0] both_cnt;   // consecutive both-high cycles, saturating
    logic [FCW-1:0] low_cnt;    // consecutive both-low cycles, saturating
    logic           armed;
    logic           hit1;
    logic           hit0;
    logic           hit_both;
    logic           hit_low;
    logic           bit_evt;
    logic           bit_val;
    logic           both_evt;

    // Saturating run-length step: restart on an inactive cycle.
    function automatic logic [FCW-1:0] run_next(input logic active,
                                                input logic [FCW-1:0] cnt);
        if (!active)
            return '0;
        else if (cnt == FILT_TOP)
            return cnt;
        else
            return cnt + 1'b1;
    endfunction

    // Flag the single cycle in which each run length reaches FILT_LEN.
    always_comb begin
        // NOTE: every output of this block gets a value on every path, so no latch is inferred.
        hit1     = im1_s && (hi1_cnt == FILT_LAST);
        hit0     = im0_s && (hi0_cnt == FILT_LAST);
        hit_both = im1_s && im0_s && (both_cnt == FILT_LAST);
        hit_low  = !im1_s && !im0_s && (low_cnt == FILT_LAST);
        // A qualified pulse is a bit only while the other line is low; a
        // two-line pulse is reported through both_evt instead.
        bit_evt  = armed && ((hit1 && !im0_s) || (hit0 && !im1_s));
        bit_val  = hit1;
        both_evt = hit_both;
    end

    // Run-length counters and the arm flag (one bit per armed period).
    always_ff @(posedge clk13MHz) begin
        if (nRST) begin
            hi1_cnt  <= '0;
            hi0_cnt  <= '0;
            both_cnt <= '0;
            low_cnt  <= '0;
            armed    <= 1'b0;
        end else begin
            hi1_cnt  <= run_next(im1_s, hi1_cnt);
            hi0_cnt  <= run_next(im0_s, hi0_cnt);
            both_cnt <= run_next(im1_s && im0_s, both_cnt);
            low_cnt  <= run_next(!im1_s && !im0_s, low_cnt);
            if (bit_evt || hit_both)
                armed <= 1'b0;
            else if (hit_low)
                armed <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Frame state machine and word assembly
    // ------------------------------------------------------------------
    state_t            state_q,    state_d;
    logic [FCW-1:0]    ho_cnt_q,   ho_cnt_d;
    logic [WORD_W-1:0] shreg_q,    shreg_d;
    logic [BCW-1:0]    bit_cnt_q,  bit_cnt_d;
    logic [IDX_W-1:0]  idx_q,      idx_d;
    logic [GCW-1:0]    gap_q,      gap_d;
    logic [WORD_W-1:0] dout_q,     dout_d;
    logic [IDX_W-1:0]  cnt_word_q, cnt_word_d;
    logic              ival_q,     ival_d;
    logic              done_q,     done_d;
    logic              err_q,      err_d;
    logic [1:0]        code_q,     code_d;
    logic [WORD_W-1:0] word_next;

    // Next state, counters and output strobes for the frame FSM.
    always_comb begin
        state_d    = state_q;
        ho_cnt_d   = ho_cnt_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        dout_d     = dout_q;
        cnt_word_d = cnt_word_q;
        ival_d     = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        code_d     = code_q;
        word_next  = {shreg_q[WORD_W-2:0], bit_val};

        unique case (state_q)
            ARM: begin
                ho_cnt_d = '0;
                if (!ho_s)
                    state_d = SYNC;
            end

            SYNC: begin
                if (!ho_s) begin
                    ho_cnt_d = '0;
                end else if (ho_cnt_q == FILT_LAST) begin
                    state_d   = RECV;
                    ho_cnt_d  = '0;
                    shreg_d   = '0;
                    bit_cnt_d = '0;
                    idx_d     = '0;
                    gap_d     = '0;
                end else begin
                    ho_cnt_d = ho_cnt_q + 1'b1;
                end
            end

            RECV: begin
                // Timeout outranks a bit arriving in the same cycle; a
                // two-line pulse never coincides with a bit event.
                if (gap_q == GAP_LAST) begin
                    err_d   = 1'b1;
                    code_d  = ERR_GAP;
                    state_d = ARM;
                end else if (both_evt) begin
                    err_d   = 1'b1;
                    code_d  = ERR_BOTH;
                    state_d = ARM;
                end else if (bit_evt) begin
                    gap_d = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        shreg_d    = word_next;
                        bit_cnt_d  = '0;
                        dout_d     = word_next;
                        ival_d     = 1'b1;
                        cnt_word_d = idx_q;
                        idx_d      = idx_q + 1'b1;
                        if (idx_q == IDX_LAST) begin
                            done_d  = 1'b1;
                            state_d = ARM;
                        end
                    end else begin
                        shreg_d   = word_next;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            default: state_d = ARM;
        endcase
    end

    // State, datapath and registered output strobes.
    always_ff @(posedge clk13MHz) begin
        if (nRST) begin
            state_q    <= ARM;
            ho_cnt_q   <= '0;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            idx_q      <= '0;
            gap_q      <= '0;
            dout_q     <= '0;
            cnt_word_q <= '0;
            ival_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            code_q     <= 2'b00;
        end else begin
            state_q    <= state_d;
            ho_cnt_q   <= ho_cnt_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            dout_q     <= dout_d;
            cnt_word_q <= cnt_word_d;
            ival_q     <= ival_d;
            done_q     <= done_d;
            err_q      <= err_d;
            code_q     <= code_d;
        end
    end

    assign bus.dout    = dout_q;
    assign bus.iVal    = ival_q;
    assign bus.cntWord = cnt_word_q;
    assign bus.frmDone = done_q;
    assign bus.frmErr  = err_q;
    assign bus.errCode = code_q;
    assign bus.busy    = (state_q != ARM);

endmodule

// File: tb/tb_im_frame_receiver_p.sv
// Self-checking bench for im_frame_receiver_p (WORD_W=8, FRAME_WORDS=6).
// Stimulus drives randomised IM1/IM0 pulse trains; a pulse-level model turns
// the driven pulses into expected words / errors with their arrival cycle.
module tb_im_frame_receiver_p;
    localparam int W  = 8;
    localparam int FW = 6;
    localparam int F  = 21;
    localparam int G  = 1023;
    // Line change to registered output: 2 synchroniser flops, FILT_LEN-1
    // further high samples, one output register.
    localparam int LAT = F + 2;

    logic clk13MHz = 1'b0;
    logic nRST     = 1'b1;
    always #38 clk13MHz = ~clk13MHz;

    im_frame_receiver_p_if #(.WORD_W(W), .FRAME_WORDS(FW)) bus ();

    im_frame_receiver_p #(
        .WORD_W(W), .FRAME_WORDS(FW), .FILT_LEN(F), .GAP_MAX(G)
    ) dut (
        .clk13MHz(clk13MHz),
        .nRST    (nRST),
        .bus     (bus)
    );

    typedef struct {
        bit           is_err;
        logic [W-1:0] word;
        int           idx;
        bit           done;
        logic [1:0]   code;
        int           at;
    } ev_t;

    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc      = 0;
    ev_t          exp_q[$];
    ev_t          mon_e;

    // Pulse-level reference model state
    bit           in_frame = 1'b0;
    logic [W-1:0] acc      = '0;
    int           nbits    = 0;
    int           widx     = 0;
    int           last_bit_at = 0;
    logic [1:0]   exp_code = 2'b00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk13MHz) cyc <= cyc + 1;

    // Scoreboard: every strobe must match the head of the expected queue.
    always @(negedge clk13MHz) begin
        if (!nRST && (bus.iVal || bus.frmErr)) begin
            check("ival_frmerr_excl", 32'(bus.iVal & bus.frmErr), 0);
            check("event_pending", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("event_kind_err", 32'(bus.frmErr), 32'(mon_e.is_err));
                check("event_cycle", cyc, mon_e.at);
                if (mon_e.is_err) begin
                    check("errCode", 32'(bus.errCode), 32'(mon_e.code));
                    check("busy_at_err", 32'(bus.busy), 0);
                end else begin
                    check("dout", 32'(bus.dout), 32'(mon_e.word));
                    check("cntWord", 32'(bus.cntWord), mon_e.idx);
                    check("frmDone", 32'(bus.frmDone), 32'(mon_e.done));
                    check("busy_at_word", 32'(bus.busy), 32'(!mon_e.done));
                end
            end
        end
        if (!nRST && bus.frmDone)
            check("frmDone_with_ival", 32'(bus.iVal), 1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk13MHz);
    endtask

    // Model: one qualified bit arrives; its effect is visible at cycle 'at'.
    task automatic model_bit(input logic b, input int at);
        ev_t e;
        if (in_frame) begin
            acc         = {acc[W-2:0], b};
            nbits++;
            last_bit_at = at;
            if (nbits == W) begin
                e.is_err = 1'b0;
                e.word   = acc;
                e.idx    = widx;
                e.done   = (widx == FW - 1);
                e.code   = 2'b00;
                e.at     = at;
                exp_q.push_back(e);
                nbits = 0;
                widx++;
                if (widx == FW)
                    in_frame = 1'b0;
            end
        end
    endtask

    task automatic model_err(input logic [1:0] code, input int at);
        ev_t e;
        e.is_err = 1'b1;
        e.word   = '0;
        e.idx    = 0;
        e.done   = 1'b0;
        e.code   = code;
        e.at     = at;
        exp_q.push_back(e);
        in_frame = 1'b0;
        exp_code = code;
    endtask

    task automatic start_frame(input int ho_len);
        bus.HO = 1'b1;
        tick(ho_len);
        bus.HO = 1'b0;
        if (ho_len >= F) begin
            in_frame = 1'b1;
            acc      = '0;
            nbits    = 0;
            widx     = 0;
        end
    endtask

    task automatic send_bit(input logic b, input int hi, input int lo);
        int at;
        at = cyc + LAT;
        if (b) bus.IM1 = 1'b1;
        else   bus.IM0 = 1'b1;
        if (hi >= F)
            model_bit(b, at);
        tick(hi);
        bus.IM1 = 1'b0;
        bus.IM0 = 1'b0;
        tick(lo);
    endtask

    task automatic glitch(input bit on_im1, input int len, input int lo);
        if (on_im1) bus.IM1 = 1'b1;
        else        bus.IM0 = 1'b1;
        tick(len);
        bus.IM1 = 1'b0;
        bus.IM0 = 1'b0;
        tick(lo);
    endtask

    task automatic both_high(input int len, input int lo);
        int at;
        at = cyc + LAT;
        bus.IM1 = 1'b1;
        bus.IM0 = 1'b1;
        if (len >= F && in_frame)
            model_err(2'b10, at);
        tick(len);
        bus.IM1 = 1'b0;
        bus.IM0 = 1'b0;
        tick(lo);
    endtask

    // mode 0: random bits, 1: alternating from 1, 2: all ones
    task automatic send_bits(input int count, input int mode, input bit glitches);
        logic b;
        int   hi;
        int   lo;
        int   glen;
        for (int k = 0; k < count; k++) begin
            case (mode)
                1:       b = (k % 2 == 0);
                2:       b = 1'b1;
                default: b = 1'($urandom & 1);
            endcase
            hi = (k % 7 == 3) ? F : int'($urandom_range(F, F + 8));
            lo = int'($urandom_range(F + 1, F + 8));
            send_bit(b, hi, lo);
            if (glitches && (k % 3 == 1)) begin
                glen = (k % 2 == 0) ? 10 : ((k % 9 == 1) ? F - 1 : int'($urandom_range(1, F - 1)));
                glitch(($urandom & 1) != 0, glen, int'($urandom_range(F + 1, F + 6)));
            end
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++)
            tick(1);
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        #(76 * 60000);
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.HO  = 1'b0;
        bus.IM1 = 1'b0;
        bus.IM0 = 1'b0;
        nRST    = 1'b1;
        tick(3);
        check("rst_dout",    32'(bus.dout), 0);
        check("rst_iVal",    32'(bus.iVal), 0);
        check("rst_cntWord", 32'(bus.cntWord), 0);
        check("rst_frmDone", 32'(bus.frmDone), 0);
        check("rst_frmErr",  32'(bus.frmErr), 0);
        check("rst_errCode", 32'(bus.errCode), 0);
        check("rst_busy",    32'(bus.busy), 0);
        nRST = 1'b0;
        tick(30);

        // Alternating IM1/IM0 frame: every word 8'hAA
        start_frame(30);
        check("busy_in_recv", 32'(bus.busy), 1);
        send_bits(W * FW, 1, 1'b0);
        drain("drain_alt_frame");

        // Random frame
        start_frame(int'($urandom_range(F + 1, 40)));
        send_bits(W * FW, 0, 1'b0);
        drain("drain_rand_frame");

        // Random frame with sub-threshold glitches between pulses
        start_frame(30);
        send_bits(W * FW, 0, 1'b1);
        drain("drain_glitch_frame");

        // Both lines high after word 3: abort, later pulses ignored
        start_frame(30);
        send_bits(4 * W + 2, 0, 1'b0);
        both_high(25, 30);
        send_bits(8, 0, 1'b0);
        drain("drain_both_err");
        check("errCode_both_hold", 32'(bus.errCode), 32'(exp_code));

        // Gap timeout after 5 bits of word 0
        start_frame(30);
        send_bits(5, 0, 1'b0);
        model_err(2'b01, last_bit_at + G);
        tick(G + 40);
        drain("drain_timeout");
        check("errCode_gap_hold", 32'(bus.errCode), 32'(exp_code));

        // HO marker one cycle short: no frame; both-high in SYNC is ignored
        start_frame(F - 1);
        send_bits(10, 0, 1'b0);
        both_high(25, 30);
        drain("drain_short_ho");
        check("errCode_sync_unchanged", 32'(bus.errCode), 32'(exp_code));

        // Marker of exactly FILT_LEN starts a normal frame
        start_frame(F);
        send_bits(W * FW, 0, 1'b0);
        drain("drain_exact_ho");

        // IM1-only frame: every word 8'hFF
        start_frame(30);
        send_bits(W * FW, 2, 1'b0);
        drain("drain_ff_frame");

        // Reset in the middle of word 2
        start_frame(30);
        send_bits(2 * W + 3, 2, 1'b0);
        drain("drain_pre_reset");
        nRST = 1'b1;
        tick(1);
        in_frame = 1'b0;
        exp_code = 2'b00;
        check("mrst_dout",    32'(bus.dout), 0);
        check("mrst_iVal",    32'(bus.iVal), 0);
        check("mrst_cntWord", 32'(bus.cntWord), 0);
        check("mrst_frmDone", 32'(bus.frmDone), 0);
        check("mrst_frmErr",  32'(bus.frmErr), 0);
        check("mrst_errCode", 32'(bus.errCode), 0);
        check("mrst_busy",    32'(bus.busy), 0);
        nRST = 1'b0;
        tick(5);

        // Clean frame after reset
        start_frame(30);
        send_bits(W * FW, 0, 1'b0);
        drain("drain_post_reset");
        check("errCode_post_reset", 32'(bus.errCode), 32'(exp_code));

        tick(50);
        check("no_leftover_events", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
